// File: rtl/mac_requant.sv
// -----------------------------------------------------------------------------
// mac_requant
//
// Output requantization stage for the MAC engine result stream. Wide signed
// accumulator values are turned into OUT_WIDTH-bit signed outputs through a
// two-stage valid/ready pipeline:
//   stage 1: arithmetic right shift with optional round-half-up
//   stage 2: optional signed saturation (otherwise truncation)
// A three-state FSM (IDLE/RUN/DONE) bounds each job to ctrl_len_i outputs and
// reports progress, saturation statistics and completion.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   test_mode_i          unused, kept for interface uniformity
//   acc_valid_i/_ready_o/_data_i   accumulator input stream (ACC_WIDTH)
//   d_valid_o/_ready_i/_data_o/_strb_o  requantized output stream (OUT_WIDTH)
//   ctrl_*_i             clear, enable, start pulse, shift, round, saturate, len
//   flags_*_o            FSM state, delivered count, saturated count, done
// -----------------------------------------------------------------------------
module mac_requant #(
    parameter int unsigned ACC_WIDTH = 64,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   test_mode_i,
    // accumulator input stream
    input  logic                   acc_valid_i,
    output logic                   acc_ready_o,
    input  logic [ACC_WIDTH-1:0]   acc_data_i,
    // requantized output stream
    output logic                   d_valid_o,
    input  logic                   d_ready_i,
    output logic [OUT_WIDTH-1:0]   d_data_o,
    output logic [OUT_WIDTH/8-1:0] d_strb_o,
    // control
    input  logic                   ctrl_clear_i,
    input  logic                   ctrl_enable_i,
    input  logic                   ctrl_start_i,
    input  logic [5:0]             ctrl_shift_i,
    input  logic                   ctrl_round_i,
    input  logic                   ctrl_saturate_i,
    input  logic [CNT_WIDTH-1:0]   ctrl_len_i,
    // status
    output logic [1:0]             flags_state_o,
    output logic [CNT_WIDTH-1:0]   flags_cnt_o,
    output logic [CNT_WIDTH-1:0]   flags_sat_cnt_o,
    output logic                   flags_done_o
);

    localparam int unsigned S1W = ACC_WIDTH + 1;

    // Saturation bounds expressed at stage-1 width.
    localparam logic signed [S1W-1:0] SAT_MAX =
        {{(S1W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [S1W-1:0] SAT_MIN =
        {{(S1W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]    sat_cnt_q, sat_cnt_d;

    logic                    s1_valid_q, s1_valid_d;
    logic signed [S1W-1:0]   r_s1_q, r_s1_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0]    r_s2_q, r_s2_d;
    logic                    r_sat_q, r_sat_d;

    logic                    s1_ready, s2_ready;
    logic                    in_hs, out_hs;
    logic [1:0]              inflight;
    logic [CNT_WIDTH-1:0]    remaining;
    logic [CNT_WIDTH-1:0]    cnt_inc;

    logic signed [S1W-1:0]   s1_x, s1_rnd, s1_res;
    logic [OUT_WIDTH-1:0]    s2_res;
    logic                    s2_sat;

    logic                    unused_ok;
    assign unused_ok = test_mode_i;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign s2_ready  = d_ready_i | ~s2_valid_q;
    assign s1_ready  = s2_ready  | ~s1_valid_q;
    assign inflight  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
    assign remaining = ctrl_len_i - cnt_q;
    assign cnt_inc   = cnt_q + CNT_WIDTH'(1);

    // Items still in the pipeline are already charged against the job length,
    // so no more than len inputs are ever accepted per job.
    assign acc_ready_o = ctrl_enable_i & (state_q == RUN) & s1_ready &
                         (CNT_WIDTH'(inflight) < remaining);
    assign d_valid_o   = ctrl_enable_i & s2_valid_q;

    assign in_hs  = acc_valid_i & acc_ready_o;
    assign out_hs = d_valid_o & d_ready_i;

    assign d_data_o = r_s2_q;
    assign d_strb_o = '1;

    // -------------------------------------------------------------------------
    // Stage 1 datapath: optional round-half-up then arithmetic shift.
    // One extra bit of headroom keeps the rounding add from overflowing.
    // -------------------------------------------------------------------------
    always_comb begin
        s1_x   = {acc_data_i[ACC_WIDTH-1], acc_data_i};
        s1_rnd = '0;
        if (ctrl_round_i && (ctrl_shift_i != 6'd0)) begin
            s1_rnd = S1W'(1) << (ctrl_shift_i - 6'd1);
        end
        s1_res = (s1_x + s1_rnd) >>> ctrl_shift_i;
    end

    // -------------------------------------------------------------------------
    // Stage 2 datapath: saturation or truncation.
    // -------------------------------------------------------------------------
    always_comb begin
        s2_res = r_s1_q[OUT_WIDTH-1:0];
        s2_sat = 1'b0;
        if (ctrl_saturate_i) begin
            if (r_s1_q > SAT_MAX) begin
                s2_res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                s2_sat = 1'b1;
            end else if (r_s1_q < SAT_MIN) begin
                s2_res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                s2_sat = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline next state
    // -------------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        r_s1_d     = r_s1_q;
        s2_valid_d = s2_valid_q;
        r_s2_d     = r_s2_q;
        r_sat_d    = r_sat_q;

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                r_s2_d  = s2_res;
                r_sat_d = s2_sat;
            end
        end

        if (s1_ready) begin
            s1_valid_d = in_hs;
            if (in_hs) begin
                r_s1_d = s1_res;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM and counters next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sat_cnt_d = sat_cnt_q;

        if (out_hs) begin
            cnt_d = cnt_inc;
            if (r_sat_q && (sat_cnt_q != '1)) begin
                sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (ctrl_start_i) begin
                    cnt_d     = '0;
                    sat_cnt_d = '0;
                    state_d   = (ctrl_len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (out_hs && (cnt_inc == ctrl_len_i)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers: clear beats enable; enable low freezes everything.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sat_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            r_s1_q     <= '0;
            s2_valid_q <= 1'b0;
            r_s2_q     <= '0;
            r_sat_q    <= 1'b0;
        end else if (ctrl_clear_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sat_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            r_s1_q     <= '0;
            s2_valid_q <= 1'b0;
            r_s2_q     <= '0;
            r_sat_q    <= 1'b0;
        end else if (ctrl_enable_i) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sat_cnt_q  <= sat_cnt_d;
            s1_valid_q <= s1_valid_d;
            r_s1_q     <= r_s1_d;
            s2_valid_q <= s2_valid_d;
            r_s2_q     <= r_s2_d;
            r_sat_q    <= r_sat_d;
        end
    end

    assign flags_state_o   = state_q;
    assign flags_cnt_o     = cnt_q;
    assign flags_sat_cnt_o = sat_cnt_q;
    assign flags_done_o    = (state_q == DONE);

endmodule

// File: doc/mac_requant.md
# mac_requant

Output requantization stage placed directly downstream of the MAC engine's `d` stream, ahead of the output streamer. It takes the wide fixed-point accumulator results and produces 32-bit outputs through a two-stage valid/ready pipeline:
- stage 1 applies an arithmetic right shift with optional round-half-up;
- stage 2 applies signed saturation.

A small FSM bounds each job to `ctrl_i.len` outputs and reports completion and saturation statistics to the HWPE controller.

## Interface
Parameters:
- `ACC_WIDTH`, 64: width of incoming accumulator data.
- `OUT_WIDTH`, 32: width of output data.
- `CNT_WIDTH`, 16: width of the length, output and saturation counters.

Ports:
- `clk_i` input 1: single clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `test_mode_i` input 1: unused; present for interface uniformity.
- `acc_i` sink (hwpe_stream_intf_stream), `ACC_WIDTH` bits: signed accumulator values.
- `d_o` source (hwpe_stream_intf_stream), `OUT_WIDTH` bits: requantized signed outputs. `strb` is always all-ones.
- `ctrl_i` input, `ctrl_requant_t` (mac_package), with fields:
  - `clear`: synchronous soft clear.
  - `enable`: global enable.
  - `start`: 1-cycle pulse.
  - `shift`: 6 bits.
  - `round`: 1 bit.
  - `saturate`: 1 bit.
  - `len`: `CNT_WIDTH` bits.
- `flags_o` output, `flags_requant_t` (mac_package), with fields:
  - `state`: 2 bits.
  - `cnt`: outputs delivered.
  - `sat_cnt`: saturated outputs.
  - `done`: 1 bit.

## Operation
- FSM states: IDLE=0, RUN=1, DONE=2.
  - IDLE → RUN on `start` when `len != 0`.
  - IDLE → DONE on `start` when `len == 0`.
  - RUN → DONE on the output handshake that makes `cnt == len`.
  - DONE → RUN on `start` when `len != 0`; this also zeroes `cnt` and `sat_cnt`.
  - `start` in RUN is ignored.
- Input acceptance: `acc_i.ready = enable & (state == RUN) & s1_ready & (inflight < len - cnt)`.
  - `inflight` = number of valid pipeline stages (0 to 2).
  - The block never accepts more than `len` inputs per job.
- Stage 1 (`r_s1`, `ACC_WIDTH+1` bits, signed):
  - `x` = sign-extended `acc_i.data`.
  - If `round` and `shift > 0`, compute `x + (1 << (shift-1))`; otherwise `x`.
  - Then arithmetic right shift by `shift`.
  - `shift >= ACC_WIDTH` is illegal: output is undefined, but handshakes must stay correct.
- Stage 2 (`r_s2`, `OUT_WIDTH` bits, and `r_sat`):
  - If `saturate` is set:
    - values above 2^(OUT_WIDTH-1)-1 become 0x7FFFFFFF, with `r_sat` = 1;
    - values below -2^(OUT_WIDTH-1) become 0x80000000, with `r_sat` = 1.
  - Otherwise the value is truncated to the low `OUT_WIDTH` bits and `r_sat` = 0.
- Handshake rules per stage:
  - `s2_ready = d_o.ready | ~s2_valid`; `s1_ready = s2_ready | ~s1_valid`.
  - A valid stage holds its data stable until its handshake completes.
  - Valid drops 1→0 only in the cycle after a handshake.
  - Stage data updates only on an input handshake.
- Counters:
  - `cnt` increments on each `d_o` handshake.
  - `sat_cnt` increments on each `d_o` handshake with `r_sat` set, and saturates at all-ones (no wrap).
  - `done` = (`state == DONE`).
- `enable` = 0 freezes all registers and FSM. During that time `d_o.valid` = 0 and `acc_i.ready` = 0.
- `clear` has priority over `enable`. It returns all state to reset values on the next edge.
- `ctrl_i` fields other than `start` must be held stable while in RUN.

## Timing
- Reset values:
  - state = IDLE, all valids 0, `r_s1`, `r_s2` and `r_sat` 0;
  - `cnt`, `sat_cnt` and `done` 0;
  - `d_o.valid` 0 and `acc_i.ready` 0.
- Latency: input handshake at cycle t gives `d_o.valid` at t+2.
- Throughput: 1 result per cycle with `d_o.ready` held high.
- Output ready is combinationally propagated to `acc_i.ready`. No valid depends combinationally on any ready.
- Simultaneous input and output handshake in the same cycle with both stages full: both stages advance and no bubble is inserted.
- Reset asserted mid-job: everything returns to reset values immediately (asynchronously). In-flight data is discarded.
- `clear` in the same cycle as `start`: `clear` wins, and the FSM stays in IDLE.
- The last output handshake and the DONE transition happen on the same edge. `flags_o.done` is visible in the following cycle.

## Test plan
- Passthrough: `shift`=0, `round`=0, `saturate`=1, `len`=4; inputs 1, -1, 100, -100 → outputs 1, 0xFFFFFFFF, 100, 0xFFFFFF9C; first output 2 cycles after the first input; `cnt`=4, `done`=1, `sat_cnt`=0.
- Rounding: `shift`=4, `round`=1; inputs 0x18, 0x17, -0x18 → outputs 2, 1, -1. With `round`=0 → outputs 1, 1, -2.
- Saturation: `shift`=0, `saturate`=1, `len`=3; inputs 0x1_0000_0000, -0x1_0000_0000, 0x7FFFFFFF → outputs 0x7FFFFFFF, 0x80000000, 0x7FFFFFFF; `sat_cnt`=2. With `saturate`=0 → the first output is 0.
- Backpressure: `len`=8, `d_o.ready` toggling pseudo-randomly and `acc_i.valid` random → all 8 values are delivered in order with none lost or duplicated; output data stays stable while `valid & ~ready`; `acc_i.ready`=0 after the 8th acceptance.
- Boundaries: `start` with `len`=0 → DONE the next cycle with no input accepted. `enable`=0 for 5 cycles mid-job → no state change. Async reset mid-job → all outputs and flags return to 0 and the FSM to IDLE.
- Restart: after DONE, `start` with `len`=2 → `cnt` and `sat_cnt` return to 0 and exactly 2 outputs are produced.
